stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/stop/clear controller and BCD time base for the stopwatch (MM:SS.cc).
//  Sits directly downstream of the per-button debouncers: takes their 1-cycle
//  press pulses and drives the 6 BCD digits consumed by the 7-seg display scanner.
//  Counts centiseconds from a 10 MHz system clock via an internal prescaler.
// PARAMETERS
//  CLK_DIV   100000  system clocks per centisecond tick (10 MHz -> 100 Hz); must be >= 2
//  PRE_W     17      prescaler width; must satisfy 2**PRE_W >= CLK_DIV
// PORTS
//  clk          in   1  system clock, 10 MHz, all logic on posedge
//  rst_n        in   1  asynchronous active-low reset
//  startstop_p  in   1  debounced start/stop press, 1-cycle pulse
//  clear_p      in   1  debounced clear press, 1-cycle pulse
//  running      out  1  high while state==RUN
//  csec_lo      out  4  BCD centiseconds units, 0..9
//  csec_hi      out  4  BCD centiseconds tens, 0..9
//  sec_lo       out  4  BCD seconds units, 0..9
//  sec_hi       out  4  BCD seconds tens, 0..5
//  min_lo       out  4  BCD minutes units, 0..9
//  min_hi       out  4  BCD minutes tens, 0..5
//  ovf_p        out  1  1-cycle pulse on wrap 59:59.99 -> 00:00.00
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, all digits=0, running=0, ovf_p=0.
//  FSM, evaluated on every clk edge:
//   IDLE : startstop_p -> RUN; clear_p alone -> stay IDLE (digits already 0).
//   RUN  : startstop_p -> STOP; clear_p ignored (also ignored when coincident).
//   STOP : clear_p -> IDLE (wins over coincident startstop_p); else startstop_p -> RUN.
//  Prescaler: increments only in RUN; tick = RUN && pre==CLK_DIV-1, pre wraps to 0.
//   Holds its value in STOP (partial centisecond kept); forced to 0 in IDLE.
//  Digits: on tick, csec_lo increments; each digit wraps at its max (9 or 5)
//   and carries into the next; carries ripple combinationally within the same
//   cycle, so all digits update together on the edge after tick is high.
//  Wrap: tick at 59:59.99 -> all digits 0 next edge, ovf_p=1 for exactly that
//   cycle; counting continues, state stays RUN.
//  Clear: transition STOP->IDLE zeroes all digits and prescaler on that edge.
//  running is registered: mirrors state, valid the edge after a transition.
//  Tick on the same edge as startstop_p in RUN: tick is counted, then STOP.
//  Digit values never leave their BCD range; out-of-range never generated.
//  Async reset asserted mid-count: immediate return to reset values, no ovf_p.
// STRUCTURE
//  Include file stopwatch_pkg.vh: state encodings ST_IDLE/ST_RUN/ST_STOP (2 bit),
//   digit max constants DIG_MAX9=4'd9, DIG_MAX5=4'd5, CLK_DIV default.
//  Sub-module bcd_digit_cnt (param MAX): inputs clk, rst_n, clr, inc;
//   outputs q[3:0], carry = inc && q==MAX. Six instances chained by carry.
//  Top holds FSM, prescaler, ovf_p register (carry out of min_hi).
// TESTING  (bench uses CLK_DIV=4)
//  1 reset, pulse startstop_p, run 40 clk -> running=1, csec=10 (hi=1,lo=0).
//  2 run to csec_lo=3, startstop_p, wait 20 clk -> digits frozen at .03; startstop_p
//    again -> resumes, next tick exactly when prescaler reaches 3 (partial kept).
//  3 RUN, pulse clear_p -> ignored, digits keep counting; STOP then clear_p ->
//    IDLE, all digits 0, running=0 next cycle.
//  4 STOP, startstop_p and clear_p same cycle -> IDLE, digits 0, not RUN.
//  5 preload-equivalent: run to 59:59.99 (force digits) then one tick ->
//    00:00.00, ovf_p high exactly 1 cycle, running stays 1.
//  6 assert rst_n=0 mid-RUN between clk edges -> outputs 0 immediately,
//    after release state IDLE, startstop_p restarts from 00:00.00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding,
// BCD digit limits and default time-base settings.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [3:0] DIG_MAX9 = 4'd9;
  localparam logic [3:0] DIG_MAX5 = 4'd5;

  // 10 MHz system clock -> 100 Hz centisecond tick
  localparam int CLK_DIV_DEF = 100000;
  localparam int PRE_W_DEF   = 17;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch time base.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   synchronous clear to 0 (has priority over inc)
//   inc    in   advance the digit by one this edge
//   q      out  registered digit value, 0..MAX
//   carry  out  combinational: inc while q==MAX (digit wraps to 0)
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = DIG_MAX9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_r;
  logic       at_max_s;

  assign at_max_s = (q_r == MAX);
  assign carry    = inc && at_max_s;
  assign q        = q_r;

  // Digit register: clear, wrap at MAX, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (inc) begin
      q_r <= at_max_s ? 4'd0 : (q_r + 4'd1);
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/clear controller and BCD time base (MM:SS.cc) for the stopwatch.
// Consumes 1-cycle debounced button pulses, divides the system clock down
// to centisecond ticks and drives six chained BCD digit counters.
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   startstop_p  in   start/stop press pulse
//   clear_p      in   clear press pulse
//   running      out  registered, high while in RUN
//   csec_lo/hi   out  centiseconds units/tens
//   sec_lo/hi    out  seconds units/tens
//   min_lo/hi    out  minutes units/tens
//   ovf_p        out  1-cycle pulse on wrap 59:59.99 -> 00:00.00
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int PRE_W   = PRE_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       startstop_p,
  input  logic       clear_p,
  output logic       running,
  output logic [3:0] csec_lo,
  output logic [3:0] csec_hi,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       ovf_p
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [PRE_W-1:0] pre_r;
  logic             running_r;
  logic             ovf_r;
  logic             tick_s;
  logic             clr_s;
  logic             c_csec_lo_s, c_csec_hi_s, c_sec_lo_s;
  logic             c_sec_hi_s, c_min_lo_s, c_min_hi_s;

  assign tick_s = (state_r == ST_RUN) && (pre_r == PRE_LAST);
  // IDLE always holds zero digits; the STOP->IDLE edge performs the clear.
  assign clr_s  = (state_r == ST_IDLE) || ((state_r == ST_STOP) && clear_p);

  // Next-state decode; clear wins over a coincident start/stop in STOP
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (startstop_p) state_nxt_s = ST_RUN;
        else             state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (startstop_p) state_nxt_s = ST_STOP;
        else             state_nxt_s = ST_RUN;
      end
      ST_STOP: begin
        if (clear_p)          state_nxt_s = ST_IDLE;
        else if (startstop_p) state_nxt_s = ST_RUN;
        else                  state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, prescaler and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pre_r     <= '0;
      running_r <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      ovf_r     <= c_min_hi_s;
      case (state_r)
        ST_RUN:  pre_r <= tick_s ? '0 : (pre_r + 1'b1);
        // partial centisecond is kept unless this edge clears
        ST_STOP: pre_r <= clear_p ? '0 : pre_r;
        default: pre_r <= '0;
      endcase
    end
  end

  bcd_digit_cnt #(.MAX(DIG_MAX9)) u_csec_lo (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(tick_s),
    .q(csec_lo), .carry(c_csec_lo_s));
  bcd_digit_cnt #(.MAX(DIG_MAX9)) u_csec_hi (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(c_csec_lo_s),
    .q(csec_hi), .carry(c_csec_hi_s));
  bcd_digit_cnt #(.MAX(DIG_MAX9)) u_sec_lo (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(c_csec_hi_s),
    .q(sec_lo), .carry(c_sec_lo_s));
  bcd_digit_cnt #(.MAX(DIG_MAX5)) u_sec_hi (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(c_sec_lo_s),
    .q(sec_hi), .carry(c_sec_hi_s));
  bcd_digit_cnt #(.MAX(DIG_MAX9)) u_min_lo (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(c_sec_hi_s),
    .q(min_lo), .carry(c_min_lo_s));
  bcd_digit_cnt #(.MAX(DIG_MAX5)) u_min_hi (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(c_min_lo_s),
    .q(min_hi), .carry(c_min_hi_s));

  assign running = running_r;
  assign ovf_p   = ovf_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a fast time base (CLK_DIV=4).
// The reference model keeps elapsed time as a plain centisecond count.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;
  localparam int CS_MAX = 359999;   // 59:59.99

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       startstop_p = 1'b0;
  logic       clear_p = 1'b0;
  logic       running, ovf_p;
  logic [3:0] csec_lo, csec_hi, sec_lo, sec_hi, min_lo, min_hi;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int m_mode = M_IDLE;
  int m_pre  = 0;
  int m_cs   = 0;
  int m_ovf  = 0;
  int ovf_seen = 0;

  stopwatch_ctrl #(.CLK_DIV(DIV), .PRE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .startstop_p(startstop_p), .clear_p(clear_p),
    .running(running), .csec_lo(csec_lo), .csec_hi(csec_hi),
    .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
    .ovf_p(ovf_p));

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int cc, ss, mm;
    cc = m_cs % 100;
    ss = (m_cs / 100) % 60;
    mm = m_cs / 6000;
    chk({tag, ".running"}, {31'd0, running}, (m_mode == M_RUN) ? 32'd1 : 32'd0);
    chk({tag, ".csec_lo"}, {28'd0, csec_lo}, cc % 10);
    chk({tag, ".csec_hi"}, {28'd0, csec_hi}, cc / 10);
    chk({tag, ".sec_lo"},  {28'd0, sec_lo},  ss % 10);
    chk({tag, ".sec_hi"},  {28'd0, sec_hi},  ss / 10);
    chk({tag, ".min_lo"},  {28'd0, min_lo},  mm % 10);
    chk({tag, ".min_hi"},  {28'd0, min_hi},  mm / 10);
    chk({tag, ".ovf_p"},   {31'd0, ovf_p},   m_ovf);
  endtask

  // one clock edge of the behavioural rules
  task automatic model_edge(input bit ss, input bit cl);
    m_ovf = 0;
    if (m_mode == M_RUN) begin
      if (m_pre == DIV - 1) begin
        m_pre = 0;
        if (m_cs == CS_MAX) begin m_cs = 0; m_ovf = 1; end
        else m_cs = m_cs + 1;
      end else begin
        m_pre = m_pre + 1;
      end
    end else if (m_mode == M_IDLE) begin
      m_pre = 0;
    end
    case (m_mode)
      M_IDLE: if (ss) m_mode = M_RUN;
      M_RUN:  if (ss) m_mode = M_STOP;
      default: begin
        if (cl) begin m_mode = M_IDLE; m_cs = 0; m_pre = 0; end
        else if (ss) m_mode = M_RUN;
      end
    endcase
  endtask

  // called at a negedge: drive pulses, clock once, check on next negedge
  task automatic step(input bit ss, input bit cl, input string tag);
    startstop_p = ss;
    clear_p     = cl;
    @(posedge clk);
    model_edge(ss, cl);
    @(negedge clk);
    startstop_p = 1'b0;
    clear_p     = 1'b0;
    if (ovf_p === 1'b1) ovf_seen++;
    chk_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
  endtask

  initial begin
    // reset
    @(negedge clk);
    @(negedge clk);
    chk_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all("post_reset");

    // 1: start and run 40 clocks -> .10
    step(1'b1, 1'b0, "t1_start");
    run(40, "t1_run");
    chk("t1_csec", {24'd0, csec_hi, csec_lo}, 32'h10);
    chk("t1_running", {31'd0, running}, 32'd1);

    // 2: run to csec_lo==3, stop, hold, resume with partial prescale kept
    for (int i = 0; i < 100 && (m_cs % 10) != 3; i++) step(1'b0, 1'b0, "t2_seek");
    chk("t2_seek_reached", m_cs % 10, 32'd3);
    run(2, "t2_partial");
    step(1'b1, 1'b0, "t2_stop");
    run(20, "t2_frozen");
    chk("t2_frozen_lo", {28'd0, csec_lo}, 32'd3);
    step(1'b1, 1'b0, "t2_resume");
    run(12, "t2_resumed");

    // 3: clear ignored in RUN, honoured in STOP
    step(1'b0, 1'b1, "t3_clr_run");
    step(1'b1, 1'b1, "t3_both_run");
    step(1'b0, 1'b0, "t3_stopped");
    step(1'b0, 1'b1, "t3_clear");
    chk("t3_idle_running", {31'd0, running}, 32'd0);
    step(1'b0, 1'b1, "t3_clr_idle");

    // 4: STOP with coincident start/stop and clear -> IDLE
    step(1'b1, 1'b0, "t4_start");
    run(9, "t4_run");
    step(1'b1, 1'b0, "t4_stop");
    step(1'b1, 1'b1, "t4_both");
    chk("t4_not_run", {31'd0, running}, 32'd0);
    run(6, "t4_idle");

    // 5: preload 59:59.99 while stopped, then wrap
    step(1'b1, 1'b0, "t5_start");
    run(5, "t5_run");
    step(1'b1, 1'b0, "t5_stop");
    force dut.u_csec_lo.q_r = 4'd9;
    force dut.u_csec_hi.q_r = 4'd9;
    force dut.u_sec_lo.q_r  = 4'd9;
    force dut.u_sec_hi.q_r  = 4'd5;
    force dut.u_min_lo.q_r  = 4'd9;
    force dut.u_min_hi.q_r  = 4'd5;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    release dut.u_csec_lo.q_r;
    release dut.u_csec_hi.q_r;
    release dut.u_sec_lo.q_r;
    release dut.u_sec_hi.q_r;
    release dut.u_min_lo.q_r;
    release dut.u_min_hi.q_r;
    m_cs = CS_MAX;
    step(1'b0, 1'b0, "t5_preloaded");
    ovf_seen = 0;
    step(1'b1, 1'b0, "t5_resume");
    run(8, "t5_wrap");
    chk("t5_ovf_count", ovf_seen, 32'd1);
    chk("t5_running", {31'd0, running}, 32'd1);

    // random button activity
    for (int i = 0; i < 400; i++) begin
      bit ss, cl;
      ss = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 11) == 0);
      step(ss, cl, "rnd");
    end

    // 6: async reset mid-RUN between edges
    if (m_mode != M_RUN) step(1'b1, (m_mode == M_STOP) ? 1'b1 : 1'b0, "t6_prep");
    if (m_mode != M_RUN) step(1'b1, 1'b0, "t6_prep2");
    run(7, "t6_run");
    #20;
    rst_n = 1'b0;
    #1;
    m_mode = M_IDLE; m_pre = 0; m_cs = 0; m_ovf = 0;
    chk_all("t6_async");
    @(negedge clk);
    chk_all("t6_held");
    rst_n = 1'b1;
    run(3, "t6_idle");
    step(1'b1, 1'b0, "t6_restart");
    run(12, "t6_count");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // safety net so the run always terminates
  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
